// File: rtl/adder_stream_pkg.sv
// adder_stream_pkg
//   Shared constants and types for the 64-bit adder streaming controller.
//   ADDER_W / ADDER_LAT : width and register depth of the attached adder wrapper.
//   occ_w()             : width of a counter that has to hold 0..DEPTH.
//   result_t            : one result FIFO entry {sum, cout}.
package adder_stream_pkg;

  localparam int ADDER_W   = 64;
  localparam int ADDER_LAT = 2;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [ADDER_W-1:0] sum;
    logic               cout;
  } result_t;

endpackage

// File: rtl/adder_stream_fifo.sv
// adder_stream_fifo
//   Synchronous result FIFO with DEPTH entries (power of two) and async-reset
//   pointers/count. Push and pop may occur in the same cycle at any fill level.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     push, push_data write one entry (dropped if full with no pop)
//     pop             read request, ignored while empty
//     head            entry at the read pointer, 0 while empty
//     empty           no entries stored
//     count           number of stored entries, 0..DEPTH
module adder_stream_fifo
  import adder_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  result_t                   push_data,
  input  logic                      pop,
  output result_t                   head,
  output logic                      empty,
  output logic [occ_w(DEPTH)-1:0]   count
);

  localparam int CW = occ_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);

  // Gating the head keeps the output at zero whenever nothing is stored.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are PW bits wide and DEPTH is a power of two, so wrap is natural.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_stream_ctrl_64u.sv
// adder_stream_ctrl_64u
//   Valid/ready front-end for a registered 64-bit adder wrapper with a fixed
//   LATENCY and no handshake of its own. Accepted operand pairs are tracked
//   with a tag pipe; when a tag exits, the wrapper's sum/cout are pushed into a
//   result FIFO. Credits (in-flight + stored) never exceed DEPTH, so no result
//   can ever find the FIFO full.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. in_ready depends only on internal counters (never on
//   in_valid); out_valid never depends on out_ready, and out_sum/out_cout hold
//   steady while out_valid is 1 and out_ready is 0.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        operand pair handshake, in_a/in_b operands
//     adder_a/adder_b          to the wrapper (pass-through of in_a/in_b)
//     adder_sum/adder_cout     from the wrapper
//     out_valid/out_ready      result handshake, out_sum/out_cout result
//     stat_ops, stat_stall     only with ADDER_STREAM_STATS_EN defined:
//                              pop count and in_valid & !in_ready cycle count
module adder_stream_ctrl_64u
  import adder_stream_pkg::*;
#(
  parameter int WIDTH   = ADDER_W,
  parameter int LATENCY = ADDER_LAT,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef ADDER_STREAM_STATS_EN
  output logic             out_cout,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stall
`else
  output logic             out_cout
`endif
);

  localparam int CW = occ_w(DEPTH);

  logic [LATENCY-1:0] tag_q;
  logic [CW-1:0]      in_flight;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        occupancy;
  logic               acc;
  logic               tag_exit;
  logic               pop;
  logic               fifo_empty;
  result_t            push_data;
  result_t            head;

  // The wrapper registers its own inputs, so operands go straight through.
  assign adder_a = in_a;
  assign adder_b = in_b;

  assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
  assign in_ready  = (occupancy < (CW+1)'(DEPTH));
  assign acc       = in_valid & in_ready;

  // The last tag stage lines up with the wrapper output for that pair.
  assign tag_exit  = tag_q[LATENCY-1];
  assign push_data = '{sum: adder_sum, cout: adder_cout};

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_sum   = head.sum;
  assign out_cout  = head.cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q     <= '0;
      in_flight <= '0;
    end else begin
      tag_q <= (tag_q << 1) | LATENCY'(acc);
      unique case ({acc, tag_exit})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  adder_stream_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_exit),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef ADDER_STREAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (pop)                  stat_ops   <= stat_ops + 32'd1;
      if (in_valid & ~in_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_stream_ctrl_64u.sv
// tb_adder_stream_ctrl_64u
//   Bench for adder_stream_ctrl_64u. Contains a behavioural two-register adder
//   wrapper model and an acceptance-order reference queue of (a+b) results.
//   Optional stats ports are exercised when ADDER_STREAM_STATS_EN is defined.
module tb_adder_stream_ctrl_64u;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] adder_a, adder_b;
  logic [W-1:0] adder_sum;
  logic         adder_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADDER_STREAM_STATS_EN
  logic [31:0]  stat_ops, stat_stall;
`endif

  adder_stream_ctrl_64u dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
`ifdef ADDER_STREAM_STATS_EN
    .out_cout   (out_cout),
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`else
    .out_cout   (out_cout)
`endif
  );

  // Wrapper model: input register, then registered 65-bit sum.
  logic [W-1:0] w_a = '0, w_b = '0;
  logic [W:0]   w_res = '0;
  always @(posedge clk) begin
    w_a   <= adder_a;
    w_b   <= adder_b;
    w_res <= {1'b0, w_a} + {1'b0, w_b};
  end
  assign adder_sum  = w_res[W-1:0];
  assign adder_cout = w_res[W];

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  logic [W:0] got_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pops_seen = 0;
  int stalls_seen = 0;

  // One clock: sample handshakes mid-cycle, then step to just after the edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
      if (out_valid && out_ready) begin
        got_q.push_back({out_cout, out_sum});
        pops_seen++;
      end
      if (in_valid && !in_ready) stalls_seen++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound, output bit timed_out);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((got_q.size() < exp_q.size() || out_valid) && n < bound) begin
      tick();
      n++;
    end
    timed_out = (n >= bound);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pops_seen = 0; stalls_seen = 0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_op();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 64'h1; in_b = 64'h2;
    n_cmp++; if (adder_a !== 64'h1 || adder_b !== 64'h2) begin n_bad++; $display("FAIL passthru got=%h/%h exp=1/2", adder_a, adder_b); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1 got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat2 got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_cmp++; if ({out_cout, out_sum} !== {1'b0, 64'h3}) begin n_bad++; $display("FAIL single_result got=%b/%h exp=0/3", out_cout, out_sum); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_popped got=%b exp=0", out_valid); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_carry();
    logic [W:0] want [2];
    bit to;
    want[0] = {1'b1, 64'h0};
    want[1] = {1'b1, 64'h0};
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1;
    tick();
    in_a = 64'h8000_0000_0000_0000; in_b = 64'h8000_0000_0000_0000;
    tick();
    drain(20, to);
    n_cmp++; if (to || got_q.size() != 2) begin n_bad++; $display("FAIL carry_count got=%0d exp=2 timeout=%0d", got_q.size(), to); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL carry_%0d got=%h exp=%h", i, got_q[i], want[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_streaming();
    int stalls = 0;
    bit to;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_a = (i % 10 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      if (in_ready !== 1'b1) stalls++;
      tick();
    end
    n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL stream_in_ready stall_cycles=%0d exp=0", stalls); end
    drain(20, to);
    n_cmp++; if (to || got_q.size() != 100 || exp_q.size() != 100) begin n_bad++; $display("FAIL stream_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stream_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [W:0] held;
    bit to;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      tick();
    end
    n_cmp++; if (exp_q.size() != 4) begin n_bad++; $display("FAIL bp_accepts got=%0d exp=4", exp_q.size()); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    held = {out_cout, out_sum};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out_cout, out_sum} !== held || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_stable got=%h exp=%h", {out_cout, out_sum}, held); end
    end
    drain(20, to);
    n_cmp++; if (to || got_q.size() != 4) begin n_bad++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_reassert got=%b exp=1", in_ready); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_simul_push_pop();
    bit to;
    // Fill to four stored results, then release while new tags keep exiting.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      tick();
    end
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      tick();
    end
    drain(30, to);
    n_cmp++; if (to || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mix_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mix_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef ADDER_STREAM_STATS_EN
  task automatic test_stats();
    n_cmp++; if (stat_ops !== 32'(pops_seen)) begin n_bad++; $display("FAIL stat_ops got=%0d exp=%0d", stat_ops, pops_seen); end
    n_cmp++; if (stat_stall !== 32'(stalls_seen)) begin n_bad++; $display("FAIL stat_stall got=%0d exp=%0d", stat_stall, stalls_seen); end
  endtask
`endif

  task automatic test_reset_mid();
    bit to;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    // Two results stored, two still in the wrapper.
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_pre got=%b/%b exp=1/0", out_valid, in_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0) begin n_bad++; $display("FAIL rm_async got=%b/%h exp=0/0", out_valid, out_sum); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    pops_seen = 0; stalls_seen = 0;
    tick(); tick();
    in_valid = 1'b1; in_a = 64'h5; in_b = 64'h6;
    tick();
    drain(20, to);
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (to || got_q.size() != 1) begin n_bad++; $display("FAIL rm_count got=%0d exp=1", got_q.size()); end
    n_cmp++; if (got_q.size() < 1 || got_q[0] !== {1'b0, 64'hB}) begin n_bad++; $display("FAIL rm_result got=%h exp=0b", (got_q.size() > 0) ? got_q[0] : 'x); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_carry();
    test_streaming();
    test_backpressure();
    test_simul_push_pop();
`ifdef ADDER_STREAM_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so a wedged run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
